// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
// A start/busy/done handshake wraps the iteration. Results are held in dedicated
// registers, and a zero divisor short-circuits straight to the DONE state.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Between iterations the partial remainder is always below the divisor,
    // so WIDTH bits suffice. Only the shifted value needs the extra bit.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] r_iter;
    logic [WIDTH-1:0] q_iter;
    logic             unused_diff_bit;

    // START is honoured in every state except CALC.
    assign accept    = start_i && (state_q != S_CALC);
    assign last_iter = (state_q == S_CALC) && (cnt_q == CW'(1));

    // One restoring step: shift {R,Q}, trial-subtract D, and keep or restore R based on the borrow.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        diff    = {1'b0, r_shift} - {2'b00, d_q};
        borrow  = diff[WIDTH+1];
        // With no borrow the difference is below D, so bit WIDTH is always zero.
        unused_diff_bit = diff[WIDTH];
        if (borrow) begin
            r_iter = r_shift[WIDTH-1:0];
            q_iter = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            r_iter = diff[WIDTH-1:0];
            q_iter = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = (divisor_i == '0) ? S_DONE : S_CALC;
                else        state_d = S_IDLE;
            end
            S_CALC: begin
                if (last_iter) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state register only.
    always_comb begin
        busy_o = (state_q == S_CALC);
        done_o = (state_q == S_DONE);
    end

    // Datapath next-state: operand capture, iteration, and result update on entry to DONE.
    always_comb begin
        cnt_d  = cnt_q;
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            q_d   = dividend_i;
            d_d   = divisor_i;
            r_d   = '0;
            cnt_d = CW'(WIDTH);
            if (divisor_i == '0) begin
                quot_d = '1;
                rem_d  = dividend_i;
                dbz_d  = 1'b1;
            end
        end else if (state_q == S_CALC) begin
            r_d   = r_iter;
            q_d   = q_iter;
            cnt_d = cnt_q - CW'(1);
            if (last_iter) begin
                quot_d = q_iter;
                rem_d  = r_iter;
                dbz_d  = 1'b0;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed WIDTH=16 scenarios plus random sweeps at WIDTH=8 and 32,
// checked against plain-arithmetic division and the quotient/remainder invariant.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start16, busy16, done16, dbz16;
    logic [15:0] a16, b16, q16, r16;
    logic        start8, busy8, done8, dbz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        start32, busy32, done32, dbz32;
    logic [31:0] a32, b32, q32, r32;

    seq_divider #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start16),
        .dividend_i(a16), .divisor_i(b16),
        .busy_o(busy16), .done_o(done16),
        .quotient_o(q16), .remainder_o(r16), .div_by_zero_o(dbz16)
    );

    seq_divider #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8),
        .dividend_i(a8), .divisor_i(b8),
        .busy_o(busy8), .done_o(done8),
        .quotient_o(q8), .remainder_o(r8), .div_by_zero_o(dbz8)
    );

    seq_divider #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start32),
        .dividend_i(a32), .divisor_i(b32),
        .busy_o(busy32), .done_o(done32),
        .quotient_o(q32), .remainder_o(r32), .div_by_zero_o(dbz32)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=16 division and wait (bounded) for DONE.
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output int cyc, output int bc, output bit held);
        logic [15:0] pq, pr;
        logic        pz;
        pq = q16; pr = r16; pz = dbz16; held = 1'b1;
        a16 = a; b16 = b; start16 = 1'b1;
        cyc = 0; bc = 0;
        do begin
            step;
            cyc++;
            start16 = 1'b0;
            if (busy16) bc++;
            if (!done16 && (q16 !== pq || r16 !== pr || dbz16 !== pz)) held = 1'b0;
        end while (!done16 && cyc < 60);
    endtask

    task automatic do16(input string tag, input logic [15:0] a, input logic [15:0] b);
        int cyc, bc;
        bit held;
        logic [15:0] eq, er;
        logic        ez;
        if (b == 0) begin eq = 16'hFFFF; er = a; ez = 1'b1; end
        else        begin eq = a / b;    er = a % b; ez = 1'b0; end
        run16(a, b, cyc, bc, held);
        check({tag, "_latency"}, cyc, (b == 0) ? 1 : 17);
        check({tag, "_busy_cycles"}, bc, (b == 0) ? 0 : 16);
        check({tag, "_quotient"}, q16, eq);
        check({tag, "_remainder"}, r16, er);
        check({tag, "_dbz"}, dbz16, ez);
        check({tag, "_results_held"}, held, 1'b1);
    endtask

    task automatic rnd8(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a, b, eq, er;
            logic       ez;
            int         sel, cyc;
            a = 8'($urandom);
            sel = $urandom_range(0, 9);
            b = (sel == 0) ? 8'd0 : (sel < 4) ? 8'($urandom_range(1, 7)) : 8'($urandom);
            if (b == 0) begin eq = '1; er = a; ez = 1'b1; end
            else        begin eq = a / b; er = a % b; ez = 1'b0; end
            a8 = a; b8 = b; start8 = 1'b1; cyc = 0;
            do begin
                step;
                cyc++;
                start8 = 1'b0;
            end while (!done8 && cyc < 40);
            check("w8_latency", cyc, (b == 0) ? 1 : 9);
            check("w8_quotient", q8, eq);
            check("w8_remainder", r8, er);
            check("w8_dbz", dbz8, ez);
            if (b != 0)
                check("w8_invariant", ((int'(q8) * int'(b) + int'(r8)) == int'(a)) && (r8 < b), 1'b1);
        end
    endtask

    task automatic rnd32(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a, b, eq, er;
            logic        ez;
            int          sel, cyc;
            longint unsigned prod;
            a = $urandom;
            sel = $urandom_range(0, 9);
            b = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 100)) :
                (sel < 6) ? (32'($urandom) >> $urandom_range(0, 31)) : 32'($urandom);
            if (b == 0) begin eq = '1; er = a; ez = 1'b1; end
            else        begin eq = a / b; er = a % b; ez = 1'b0; end
            a32 = a; b32 = b; start32 = 1'b1; cyc = 0;
            do begin
                step;
                cyc++;
                start32 = 1'b0;
            end while (!done32 && cyc < 80);
            check("w32_latency", cyc, (b == 0) ? 1 : 33);
            check("w32_quotient", q32, eq);
            check("w32_remainder", r32, er);
            check("w32_dbz", dbz32, ez);
            if (b != 0) begin
                prod = longint'(q32) * longint'(b) + longint'(r32);
                check("w32_invariant", (prod == longint'(a)) && (r32 < b), 1'b1);
            end
        end
    endtask

    initial begin
        int cyc, dc, first;
        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; a8  = '0; b8  = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        #1;
        check("reset_busy", busy16, 1'b0);
        check("reset_done", done16, 1'b0);
        check("reset_quotient", q16, 16'd0);
        check("reset_remainder", r16, 16'd0);
        check("reset_dbz", dbz16, 1'b0);
        step;
        step;
        rst_n = 1'b1;
        step;

        do16("d100_7", 16'd100, 16'd7);
        step;
        check("done_single_pulse", done16, 1'b0);
        check("hold_after_done", q16, 16'd14);
        do16("dffff_1", 16'hFFFF, 16'd1);
        step;
        do16("d3_10", 16'd3, 16'd10);
        do16("dffff_ffff", 16'hFFFF, 16'hFFFF);
        step;
        do16("d5_0", 16'd5, 16'd0);
        step;
        do16("d9_3", 16'd9, 16'd3);
        step;

        // START during CALC must be ignored.
        a16 = 16'd1000; b16 = 16'd9; start16 = 1'b1;
        step;
        start16 = 1'b0;
        cyc = 1; dc = 0; first = 0;
        while (cyc < 40) begin
            if (cyc == 5) begin a16 = 16'd50; b16 = 16'd5; start16 = 1'b1; end
            else start16 = 1'b0;
            step;
            cyc++;
            if (done16) begin
                dc++;
                if (first == 0) first = cyc;
            end
        end
        check("ignore_start_done_count", dc, 1);
        check("ignore_start_latency", first, 17);
        check("ignore_start_quotient", q16, 16'd111);
        check("ignore_start_remainder", r16, 16'd1);

        // Back-to-back: the second START is issued in the DONE cycle of the first.
        do16("b2b_200_3", 16'd200, 16'd3);
        check("b2b_in_done_cycle", done16, 1'b1);
        do16("b2b_77_8", 16'd77, 16'd8);

        // Reset in the middle of a division.
        a16 = 16'd1000; b16 = 16'd9; start16 = 1'b1;
        step;
        start16 = 1'b0;
        repeat (7) step;
        check("midcalc_busy_before", busy16, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_busy", busy16, 1'b0);
        check("midcalc_rst_done", done16, 1'b0);
        check("midcalc_rst_quotient", q16, 16'd0);
        check("midcalc_rst_remainder", r16, 16'd0);
        check("midcalc_rst_dbz", dbz16, 1'b0);
        step;
        step;
        rst_n = 1'b1;
        dc = 0;
        repeat (25) begin
            step;
            if (done16) dc++;
        end
        check("midcalc_no_done", dc, 0);
        do16("d42_6", 16'd42, 16'd6);

        rnd8(1000);
        rnd32(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
